// File: rtl/bcd_disp_pkg.sv
// Shared constants and the active-low 7-segment decoder for the BCD counter/display block.
package bcd_disp_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    // Cathode pattern {g,f,e,d,c,b,a}, active-low; non-BCD codes go dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/bcd_counter_display_digit.sv
// One BCD decade: load, up/down step and a combinational ripple-out to the next decade.
import bcd_disp_pkg::*;

module bcd_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       co
);
    assign co = step && (up ? (q == BCD_MAX) : (q == 4'd0));

    always_ff @(posedge clk) begin
        if (rst)
            q <= 4'd0;
        else if (load)
            q <= (d > BCD_MAX) ? 4'd0 : d;
        else if (step) begin
            if (up)
                q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
            else
                q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
        end
    end
endmodule

// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with prescaler, wrap pulse and multiplexed 7-segment scan.
// Optional leading-zero blanking is enabled by defining BCD_LZ_BLANK_EN.
import bcd_disp_pkg::*;

module bcd_counter_display #(
    parameter int DIGITS      = 2,
    parameter int AN_WIDTH    = 8,
    parameter int COUNT_DIV   = 1,
    parameter int REFRESH_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  carry,
    output logic [AN_WIDTH-1:0]   anode,
    output logic [6:0]            seg
);
    localparam int PW = (COUNT_DIV > 1)   ? $clog2(COUNT_DIV)   : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(COUNT_DIV - 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]             pre;
    logic [RW-1:0]             rcnt;
    logic [IW-1:0]             idx;
    logic [DIGITS-1:0][3:0]    q;
    logic [DIGITS-1:0]         stp;
    logic [DIGITS-1:0]         co;
    logic [AN_WIDTH-1:0]       an_nxt;
    logic [6:0]                seg_nxt;
    logic [3:0]                cur;

    // A load in the same cycle as a prescaler tick suppresses the step and its carry.
    assign stp[0] = en && !load && (pre == PRE_LAST);
    assign bcd    = q;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_dig
            if (i > 0) begin : g_chain
                assign stp[i] = co[i-1];
            end
            bcd_digit u_dig (
                .clk  (clk),
                .rst  (rst),
                .step (stp[i]),
                .up   (up),
                .load (load),
                .d    (load_val[4*i +: 4]),
                .q    (q[i]),
                .co   (co[i])
            );
        end
    endgenerate

`ifdef BCD_LZ_BLANK_EN
    logic zero_above;
    logic blank;

    always_comb begin
        an_nxt     = '1;
        cur        = 4'd0;
        zero_above = 1'b1;
        blank      = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (q[i] == 4'd0);
            if (idx == IW'(i)) begin
                an_nxt[i] = 1'b0;
                cur       = q[i];
                if (i != 0) blank = zero_above;
            end
        end
        seg_nxt = blank ? SEG_BLANK : seg_decode(cur);
    end
`else
    always_comb begin
        an_nxt = '1;
        cur    = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                an_nxt[i] = 1'b0;
                cur       = q[i];
            end
        end
        seg_nxt = seg_decode(cur);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pre   <= '0;
            carry <= 1'b0;
            rcnt  <= '0;
            idx   <= '0;
            anode <= '1;
            seg   <= SEG_BLANK;
        end else begin
            if (en)
                pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
            carry <= co[DIGITS-1];
            if (rcnt == REF_LAST) begin
                rcnt <= '0;
                idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
            anode <= an_nxt;
            seg   <= seg_nxt;
        end
    end
endmodule

// File: tb/tb_bcd_counter_display.sv
// Bench for bcd_counter_display: vector table, hand sequences and random stimulus vs an integer model.
module tb_bcd_counter_display;
    localparam int RD = 4;

    logic clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    logic       rst, en, up, load;
    logic [7:0] load_val;
    logic [7:0] bcd1, bcd3, an1, an3;
    logic [6:0] seg1, seg3;
    logic       carry1, carry3;

    bcd_counter_display #(.DIGITS(2), .AN_WIDTH(8), .COUNT_DIV(1), .REFRESH_DIV(RD)) dut (
        .clk(clk_tb), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .bcd(bcd1), .carry(carry1), .anode(an1), .seg(seg1));

    bcd_counter_display #(.DIGITS(2), .AN_WIDTH(8), .COUNT_DIV(3), .REFRESH_DIV(RD)) dut3 (
        .clk(clk_tb), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .bcd(bcd3), .carry(carry3), .anode(an3), .seg(seg3));

    int checks = 0, failures = 0;
    bit chk_on = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dec(input int d);
        case (d)
            0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30; 4: return 7'h19;
            5: return 7'h12; 6: return 7'h02; 7: return 7'h78; 8: return 7'h00; 9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int cnt, input int d);
        int dig = (d == 1) ? cnt / 10 : cnt % 10;
`ifdef BCD_LZ_BLANK_EN
        if (d == 1 && dig == 0) return 7'h7F;
`endif
        return dec(dig);
    endfunction

    function automatic int clampv(input logic [7:0] v);
        int hi = (v[7:4] > 4'd9) ? 0 : int'(v[7:4]);
        int lo = (v[3:0] > 4'd9) ? 0 : int'(v[3:0]);
        return hi * 10 + lo;
    endfunction

    function automatic logic [7:0] to_bcd(input int c);
        return {4'(c / 10), 4'(c % 10)};
    endfunction

    // Reference model: the count is a plain integer 0..99; index 0 tracks dut, 1 tracks dut3.
    int         m_cnt[2], m_pre[2], m_tick[2];
    bit         m_carry[2];
    logic [7:0] m_an[2];
    logic [6:0] m_seg[2];
    int         md, mcd;
    bit         mfire;

    always @(posedge clk_tb) begin
        for (int k = 0; k < 2; k++) begin
            mcd = (k == 0) ? 1 : 3;
            if (rst) begin
                m_cnt[k] = 0; m_pre[k] = 0; m_tick[k] = 0; m_carry[k] = 0;
                m_an[k] = 8'hFF; m_seg[k] = 7'h7F;
            end else begin
                md        = (m_tick[k] / RD) % 2;
                m_an[k]   = ~(8'h01 << md);
                m_seg[k]  = exp_seg(m_cnt[k], md);
                m_tick[k] = m_tick[k] + 1;
                mfire     = 0;
                if (en) begin
                    mfire    = (m_pre[k] == mcd - 1);
                    m_pre[k] = (m_pre[k] + 1) % mcd;
                end
                m_carry[k] = 0;
                if (load)
                    m_cnt[k] = clampv(load_val);
                else if (mfire) begin
                    if (up) begin
                        m_carry[k] = (m_cnt[k] == 99);
                        m_cnt[k]   = (m_cnt[k] + 1) % 100;
                    end else begin
                        m_carry[k] = (m_cnt[k] == 0);
                        m_cnt[k]   = (m_cnt[k] + 99) % 100;
                    end
                end
            end
        end
    end

    always @(negedge clk_tb) begin
        if (chk_on) begin
            chk("model_bcd1", bcd1, to_bcd(m_cnt[0]));
            chk("model_carry1", carry1, m_carry[0]);
            chk("model_anode1", an1, m_an[0]);
            chk("model_seg1", seg1, m_seg[0]);
            chk("model_bcd3", bcd3, to_bcd(m_cnt[1]));
            chk("model_carry3", carry3, m_carry[1]);
            chk("model_anode3", an3, m_an[1]);
            chk("model_seg3", seg3, m_seg[1]);
        end
    end

    typedef struct {
        logic       rst, en, up, load;
        logic [7:0] lv;
        logic [7:0] eb;
        logic       ec;
    } vec_t;
    vec_t tv[18];

    int ccount, fe, fd, bad, n;

    initial begin
        tv[0]  = '{1, 0, 1, 0, 8'h00, 8'h00, 0};
        tv[1]  = '{1, 0, 1, 0, 8'h00, 8'h00, 0};
        tv[2]  = '{0, 1, 0, 0, 8'h00, 8'h99, 1};
        tv[3]  = '{0, 1, 0, 0, 8'h00, 8'h98, 0};
        tv[4]  = '{0, 1, 0, 0, 8'h00, 8'h97, 0};
        tv[5]  = '{0, 1, 1, 1, 8'h47, 8'h47, 0};
        tv[6]  = '{0, 1, 1, 1, 8'h99, 8'h99, 0};
        tv[7]  = '{0, 1, 1, 0, 8'h00, 8'h00, 1};
        tv[8]  = '{0, 1, 1, 1, 8'h4C, 8'h40, 0};
        tv[9]  = '{0, 1, 1, 1, 8'hC5, 8'h05, 0};
        tv[10] = '{0, 0, 1, 0, 8'h00, 8'h05, 0};
        tv[11] = '{0, 1, 1, 0, 8'h00, 8'h06, 0};
        tv[12] = '{0, 1, 0, 0, 8'h00, 8'h05, 0};
        tv[13] = '{0, 0, 1, 1, 8'h09, 8'h09, 0};
        tv[14] = '{0, 1, 1, 0, 8'h00, 8'h10, 0};
        tv[15] = '{0, 1, 0, 0, 8'h00, 8'h09, 0};
        tv[16] = '{1, 1, 1, 1, 8'h33, 8'h00, 0};
        tv[17] = '{0, 0, 1, 0, 8'h00, 8'h00, 0};

        rst = 1; en = 0; up = 1; load = 0; load_val = 8'h00;
        repeat (2) @(negedge clk_tb);
        chk("reset_bcd", bcd1, 8'h00);
        chk("reset_anode", an1, 8'hFF);
        chk("reset_seg", seg1, 7'h7F);
        chk("reset_carry", carry1, 1'b0);
        chk_on = 1;

        // Full up count with a single wrap pulse
        rst = 0; en = 1; up = 1; ccount = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_tb);
            if (carry1) ccount++;
            if (i == 98) chk("up_at_99", bcd1, 8'h99);
        end
        chk("up_wrap_bcd", bcd1, 8'h00);
        chk("up_carry_count", ccount, 1);

        for (int i = 0; i < 18; i++) begin
            rst = tv[i].rst; en = tv[i].en; up = tv[i].up; load = tv[i].load; load_val = tv[i].lv;
            @(negedge clk_tb);
            chk($sformatf("vec%0d_bcd", i), bcd1, tv[i].eb);
            chk($sformatf("vec%0d_carry", i), carry1, tv[i].ec);
        end

        // Hold at 35 with the scan still running
        rst = 0; en = 0; load = 1; load_val = 8'h35;
        @(negedge clk_tb);
        load = 0;
        repeat (2) @(negedge clk_tb);
        fe = 0; fd = 0; bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_tb);
            if (bcd1 !== 8'h35) bad++;
            if (an1 === 8'hFE && seg1 === 7'h12) fe++;
            else if (an1 === 8'hFD && seg1 === 7'h30) fd++;
            else bad++;
        end
        chk("hold_bad_samples", bad, 0);
        chk("scan_digit0_cycles", fe, 20);
        chk("scan_digit1_cycles", fd, 20);

        // Prescaler of 3 on dut3, counting only enabled cycles
        rst = 1; en = 0; up = 1;
        @(negedge clk_tb);
        rst = 0;
        en = 1; @(negedge clk_tb); chk("div3_a", bcd3, 8'h00);
        en = 0; @(negedge clk_tb); chk("div3_b", bcd3, 8'h00);
        en = 1; @(negedge clk_tb); chk("div3_c", bcd3, 8'h00);
        en = 1; @(negedge clk_tb); chk("div3_d", bcd3, 8'h01);
        en = 0; load = 1; load_val = 8'h57;
        @(negedge clk_tb);
        load = 0;
        chk("div3_load", bcd3, 8'h57);
        rst = 1; en = 1;
        @(negedge clk_tb);
        chk("rst_mid_bcd3", bcd3, 8'h00);
        chk("rst_mid_anode3", an3, 8'hFF);
        chk("rst_mid_seg3", seg3, 7'h7F);
        rst = 0; en = 0;

        // Upper digit of 05 and digit 0 of 00
        load = 1; load_val = 8'h05;
        @(negedge clk_tb);
        load = 0;
        @(negedge clk_tb);
        n = 0;
        while (an1 !== 8'hFD && n < 10) begin @(negedge clk_tb); n++; end
        chk("lz_wait_digit1", an1, 8'hFD);
`ifdef BCD_LZ_BLANK_EN
        chk("lz_digit1_seg", seg1, 7'h7F);
`else
        chk("lz_digit1_seg", seg1, 7'h40);
`endif
        load = 1; load_val = 8'h00;
        @(negedge clk_tb);
        load = 0;
        @(negedge clk_tb);
        n = 0;
        while (an1 !== 8'hFE && n < 10) begin @(negedge clk_tb); n++; end
        chk("lz_wait_digit0", an1, 8'hFE);
        chk("lz_digit0_seg", seg1, 7'h40);

        // Random traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom % 150) == 0;
            load     = ($urandom % 20) == 0;
            en       = ($urandom % 5) != 0;
            if (($urandom % 40) == 0) up = ~up;
            load_val = 8'($urandom);
            @(negedge clk_tb);
        end

        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
